hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/hazard_ctl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// hazard_ctl -- pipeline hazard controller (stall / flush / bubble / issue).
//
// Tracks one pending-write bit per GP register (and per SR register when
// HAZARD_SR_TRACK_EN is defined). An ID instruction that touches a busy
// register is stalled until the matching writeback retires. A taken branch
// flushes IF/ID for the branch cycle plus FLUSH_CYCLES cycles. A stall that
// lasts STALL_TIMEOUT cycles is treated as a deadlock: all pending bits are
// dropped and ow_deadlock pulses once.
//
// Optional feature macro: HAZARD_SR_TRACK_EN (SR pending bits + SR hazards).
//
// Ports
//   iw_clk, iw_rst                  clock, synchronous active-high reset
//   iw_id_valid                     ID latch holds a real instruction
//   iw_has_src_gp/iw_src_gp         GP source read
//   iw_has_tgt_gp/iw_tgt_gp/_we     GP target read / write
//   iw_has_src_sr/iw_src_sr         SR source read
//   iw_tgt_sr/iw_tgt_sr_we          SR target write
//   iw_branch_taken                 EX resolved a taken branch
//   iw_wb_gp_we/iw_wb_gp            GP writeback
//   iw_wb_sr_we/iw_wb_sr            SR writeback
//   ow_stall/ow_flush/ow_bubble/ow_issue  pipeline control
//   ow_state                        0 RUN, 1 STALL, 2 FLUSH
//   ow_deadlock                     one-cycle pulse on stall timeout
`ifndef SIZE_SRC_GP
`define SIZE_SRC_GP 5
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 5
`endif
`ifndef SIZE_SRC_SR
`define SIZE_SRC_SR 3
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 3
`endif

module hazard_ctl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic                    iw_id_valid,
  input  logic                    iw_has_src_gp,
  input  logic [`SIZE_SRC_GP-1:0] iw_src_gp,
  input  logic                    iw_has_tgt_gp,
  input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  input  logic                    iw_has_src_sr,
  input  logic [`SIZE_SRC_SR-1:0] iw_src_sr,
  input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  input  logic                    iw_branch_taken,
  input  logic                    iw_wb_gp_we,
  input  logic [`SIZE_TGT_GP-1:0] iw_wb_gp,
  input  logic                    iw_wb_sr_we,
  input  logic [`SIZE_TGT_SR-1:0] iw_wb_sr,
  output logic                    ow_stall,
  output logic                    ow_flush,
  output logic                    ow_bubble,
  output logic                    ow_issue,
  output logic [1:0]              ow_state,
  output logic                    ow_deadlock
);

  localparam int unsigned NGP = 1 << `SIZE_TGT_GP;

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [3:0]     fcnt_q, fcnt_d;
  logic [7:0]     scnt_q, scnt_d;
  logic [NGP-1:0] pend_gp_q, pend_gp_d, busy_gp;
  logic           haz_gp, haz_sr, hazard;

  // Busy = pending and not retiring this very cycle, so issue resumes in the
  // same cycle as the blocking writeback.
  always_comb begin
    busy_gp = pend_gp_q;
    if (iw_wb_gp_we) busy_gp[iw_wb_gp] = 1'b0;
    haz_gp = (iw_has_src_gp && busy_gp[iw_src_gp]) ||
             (iw_has_tgt_gp && busy_gp[iw_tgt_gp]);
  end

`ifdef HAZARD_SR_TRACK_EN
  localparam int unsigned NSR = 1 << `SIZE_TGT_SR;
  logic [NSR-1:0] pend_sr_q, pend_sr_d, busy_sr;

  always_comb begin
    busy_sr = pend_sr_q;
    if (iw_wb_sr_we) busy_sr[iw_wb_sr] = 1'b0;
    haz_sr = (iw_has_src_sr && busy_sr[iw_src_sr]) ||
             (iw_tgt_sr_we  && busy_sr[iw_tgt_sr]);
  end

  always_comb begin
    pend_sr_d = pend_sr_q;
    if (iw_wb_sr_we) pend_sr_d[iw_wb_sr] = 1'b0;
    if (ow_issue && iw_tgt_sr_we) pend_sr_d[iw_tgt_sr] = 1'b1;  // set wins
    if (ow_deadlock) pend_sr_d = '0;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) pend_sr_q <= '0;
    else        pend_sr_q <= pend_sr_d;
  end
`else
  // SR tracking compiled out: the SR inputs are intentionally ignored.
  logic unused_sr;
  assign unused_sr = ^{iw_has_src_sr, iw_src_sr, iw_tgt_sr, iw_tgt_sr_we,
                       iw_wb_sr_we, iw_wb_sr};
  assign haz_sr = 1'b0;
`endif

  assign hazard      = iw_id_valid && (haz_gp || haz_sr);
  assign ow_flush    = (state_q == FLUSH) || iw_branch_taken;
  assign ow_stall    = hazard && !ow_flush;
  assign ow_issue    = iw_id_valid && !ow_stall && !ow_flush;
  assign ow_bubble   = !ow_issue;
  assign ow_state    = state_q;
  // Fires on the stall cycle whose increment would reach the timeout.
  assign ow_deadlock = ow_stall && (({1'b0, scnt_q} + 9'd1) == 9'(STALL_TIMEOUT));

  always_comb begin
    pend_gp_d = pend_gp_q;
    if (iw_wb_gp_we) pend_gp_d[iw_wb_gp] = 1'b0;
    if (ow_issue && iw_tgt_gp_we) pend_gp_d[iw_tgt_gp] = 1'b1;  // set wins
    if (ow_deadlock) pend_gp_d = '0;
  end

  always_comb begin
    scnt_d = scnt_q;
    if (!ow_stall || ow_deadlock) scnt_d = '0;
    else if (scnt_q != 8'hFF)     scnt_d = scnt_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (iw_branch_taken) begin
      state_d = FLUSH;                        // also restarts an active flush
      fcnt_d  = 4'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      if (fcnt_q == 4'd0) state_d = RUN;
      else                fcnt_d  = fcnt_q - 4'd1;
    end else if (ow_deadlock) begin
      state_d = RUN;                          // pending bits dropped: nothing blocks
    end else if (hazard) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      scnt_q    <= '0;
      pend_gp_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      scnt_q    <= scnt_d;
      pend_gp_q <= pend_gp_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: a per-cycle vector table followed by
// hand-written deadlock and SR-dependency sequences.
`ifndef SIZE_SRC_GP
`define SIZE_SRC_GP 5
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 5
`endif
`ifndef SIZE_SRC_SR
`define SIZE_SRC_SR 3
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 3
`endif

module tb_hazard_ctl;
  logic clk = 1'b0;
  logic rst, id_valid, has_src_gp, has_tgt_gp, tgt_gp_we, has_src_sr, tgt_sr_we;
  logic branch, wb_gp_we, wb_sr_we;
  logic [`SIZE_SRC_GP-1:0] src_gp;
  logic [`SIZE_TGT_GP-1:0] tgt_gp, wb_gp;
  logic [`SIZE_SRC_SR-1:0] src_sr;
  logic [`SIZE_TGT_SR-1:0] tgt_sr, wb_sr;
  logic stall, flush, bubble, issue, deadlock;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctl #(.FLUSH_CYCLES(2), .STALL_TIMEOUT(255)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_id_valid(id_valid),
    .iw_has_src_gp(has_src_gp), .iw_src_gp(src_gp),
    .iw_has_tgt_gp(has_tgt_gp), .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we),
    .iw_has_src_sr(has_src_sr), .iw_src_sr(src_sr),
    .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we),
    .iw_branch_taken(branch),
    .iw_wb_gp_we(wb_gp_we), .iw_wb_gp(wb_gp),
    .iw_wb_sr_we(wb_sr_we), .iw_wb_sr(wb_sr),
    .ow_stall(stall), .ow_flush(flush), .ow_bubble(bubble), .ow_issue(issue),
    .ow_state(state), .ow_deadlock(deadlock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v, hs, ht, twe, br, wbwe;
    int   s, t, wb;
    logic e_stall, e_flush, e_issue;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic hs, int s, logic ht, int t,
                              logic twe, logic br, logic wbwe, int wb,
                              logic es, logic ef, logic ei, logic [1:0] est);
    vec_t x;
    x.rst = r; x.v = v; x.hs = hs; x.s = s; x.ht = ht; x.t = t; x.twe = twe;
    x.br = br; x.wbwe = wbwe; x.wb = wb;
    x.e_stall = es; x.e_flush = ef; x.e_issue = ei; x.e_state = est;
    return x;
  endfunction

  task automatic clear_in();
    rst = 0; id_valid = 0; has_src_gp = 0; src_gp = '0; has_tgt_gp = 0;
    tgt_gp = '0; tgt_gp_we = 0; has_src_sr = 0; src_sr = '0; tgt_sr = '0;
    tgt_sr_we = 0; branch = 0; wb_gp_we = 0; wb_gp = '0; wb_sr_we = 0; wb_sr = '0;
  endtask

  task automatic drive(vec_t x);
    clear_in();
    rst = x.rst; id_valid = x.v; has_src_gp = x.hs; src_gp = `SIZE_SRC_GP'(x.s);
    has_tgt_gp = x.ht; tgt_gp = `SIZE_TGT_GP'(x.t); tgt_gp_we = x.twe;
    branch = x.br; wb_gp_we = x.wbwe; wb_gp = `SIZE_TGT_GP'(x.wb);
  endtask

  // Outputs packed as {stall, flush, issue, bubble, state, deadlock}.
  task automatic chk(string name, logic es, logic ef, logic ei, logic [1:0] est, logic edl);
    logic [6:0] exp_v, act_v;
    exp_v = {es, ef, ei, ~ei, est, edl};
    act_v = {stall, flush, issue, bubble, state, deadlock};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got stall/flush/issue/bubble/state/dl=%b expected %b", name, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic sr_on;

  initial begin
`ifdef HAZARD_SR_TRACK_EN
    sr_on = 1'b1;
`else
    sr_on = 1'b0;
`endif
    //             rst v hs s ht t twe br wbwe wb   stall flush issue state
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0)); // 0 reset state, bubble
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,1,0)); // 1 plain issue
    vecs.push_back(mk(0,1,0,0,1,3,1,0,0,0, 0,0,1,0)); // 2 issue write r3
    vecs.push_back(mk(0,1,1,3,0,0,0,0,0,0, 1,0,0,0)); // 3 read r3 -> stall
    vecs.push_back(mk(0,1,1,3,0,0,0,0,0,0, 1,0,0,1)); // 4 STALL state
    vecs.push_back(mk(0,1,1,3,0,0,0,0,1,3, 0,0,1,1)); // 5 wb r3 -> issue same cycle
    vecs.push_back(mk(0,1,1,3,0,0,0,0,0,0, 0,0,1,0)); // 6 r3 now free
    vecs.push_back(mk(0,1,0,0,1,7,1,0,0,0, 0,0,1,0)); // 7 write r7
    vecs.push_back(mk(0,1,0,0,1,7,0,0,0,0, 1,0,0,0)); // 8 target read r7 stalls
    vecs.push_back(mk(0,1,0,0,1,7,0,0,1,7, 0,0,1,1)); // 9 wb r7
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0)); // 10 idle
    vecs.push_back(mk(0,1,0,0,1,9,1,1,0,0, 0,1,0,0)); // 11 branch, r9 write suppressed
    vecs.push_back(mk(0,1,0,0,1,9,1,0,0,0, 0,1,0,2)); // 12 FLUSH 1
    vecs.push_back(mk(0,1,0,0,1,9,1,0,0,0, 0,1,0,2)); // 13 FLUSH 2
    vecs.push_back(mk(0,1,1,9,0,0,0,0,0,0, 0,0,1,0)); // 14 r9 never set
    vecs.push_back(mk(0,1,0,0,1,4,1,0,0,0, 0,0,1,0)); // 15 write r4
    vecs.push_back(mk(0,1,1,4,1,6,1,0,0,0, 1,0,0,0)); // 16 stall on r4 (writes r6)
    vecs.push_back(mk(0,1,1,4,1,6,1,0,0,0, 1,0,0,1)); // 17 STALL
    vecs.push_back(mk(0,1,1,4,1,6,1,1,0,0, 0,1,0,1)); // 18 branch in STALL
    vecs.push_back(mk(0,1,1,6,0,0,0,0,0,0, 0,1,0,2)); // 19 FLUSH
    vecs.push_back(mk(0,1,1,6,0,0,0,0,0,0, 0,1,0,2)); // 20 FLUSH
    vecs.push_back(mk(0,1,1,6,0,0,0,0,1,4, 0,0,1,0)); // 21 r6 clear; retire r4
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,0,0)); // 22 branch
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,2)); // 23 FLUSH
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,0,2)); // 24 branch in FLUSH reloads
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,2)); // 25
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,2)); // 26
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0)); // 27 back to RUN
    vecs.push_back(mk(0,1,0,0,1,5,1,0,0,0, 0,0,1,0)); // 28 write r5
    vecs.push_back(mk(0,1,0,0,1,5,1,0,1,5, 0,0,1,0)); // 29 set+clear r5 same cycle
    vecs.push_back(mk(0,1,1,5,0,0,0,0,0,0, 1,0,0,0)); // 30 r5 still pending
    vecs.push_back(mk(0,1,1,5,0,0,0,0,1,5, 0,0,1,1)); // 31 retire r5
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0)); // 32 idle
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,0,0)); // 33 branch
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,2)); // 34 FLUSH 1
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,1,0,2)); // 35 reset on FLUSH 2
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,1,0)); // 36 no residual flush
    vecs.push_back(mk(0,1,0,0,1,2,1,0,0,0, 0,0,1,0)); // 37 write r2
    vecs.push_back(mk(0,1,1,2,0,0,0,0,0,0, 1,0,0,0)); // 38 stall
    vecs.push_back(mk(1,1,1,2,0,0,0,0,0,0, 1,0,0,1)); // 39 reset in STALL
    vecs.push_back(mk(0,1,1,2,0,0,0,0,0,0, 0,0,1,0)); // 40 pending cleared

    clear_in();
    rst = 1;
    step(); step();
    clear_in();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
          vecs[i].e_issue, vecs[i].e_state, 1'b0);
      step();
    end

    // Deadlock: r1 pending, hold a reader for 255 stall cycles.
    clear_in(); id_valid = 1; has_tgt_gp = 1; tgt_gp = 1; tgt_gp_we = 1;
    @(negedge clk); chk("dl_setup", 0, 0, 1, 2'd0, 0);
    step();
    clear_in(); id_valid = 1; has_src_gp = 1; src_gp = 1;
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk);
      chk($sformatf("dl_cyc%0d", c), 1, 0, 0, (c == 1) ? 2'd0 : 2'd1, (c == 255));
      step();
    end
    @(negedge clk);
    n_tests++;
    if (!(stall === 1'b0 && issue === 1'b1 && deadlock === 1'b0)) begin
      n_fail++;
      $display("FAIL dl_recover: got stall=%b issue=%b dl=%b expected 0 1 0", stall, issue, deadlock);
    end
    step();

    // SR dependency: stalls only when SR tracking is compiled in.
    clear_in(); id_valid = 1; tgt_sr = 2; tgt_sr_we = 1;
    @(negedge clk); chk("sr_set", 0, 0, 1, 2'd0, 0);
    step();
    clear_in(); id_valid = 1; has_src_sr = 1; src_sr = 2;
    @(negedge clk); chk("sr_src", sr_on, 0, !sr_on, 2'd0, 0);
    step();
    clear_in(); id_valid = 1; tgt_sr = 2; tgt_sr_we = 1;
    @(negedge clk); chk("sr_tgt", sr_on, 0, !sr_on, sr_on ? 2'd1 : 2'd0, 0);
    step();
    clear_in(); id_valid = 1; has_src_sr = 1; src_sr = 2; wb_sr_we = 1; wb_sr = 2;
    @(negedge clk); chk("sr_wb", 0, 0, 1, sr_on ? 2'd1 : 2'd0, 0);
    step();
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
